reg_alu_ctrl: RTL and testbench
===============================

REG_ALU_CTRL -- requirements
Module: reg_alu_ctrl

Interface
REQ-001 SHALL have parameter: ZERO_REG_PROTECT, default 1, meaning "1 = writes with rd==0 are suppressed".
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: instr_valid  input  1  instruction word offered.
REQ-005 SHALL have port: instr  input  32  R-type word: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0].
REQ-006 SHALL have port: instr_ready  output  1  controller can accept an instruction.
REQ-007 SHALL have ports: R_Addr_A, R_Addr_B, W_Addr  output  5 each  register-file read/write addresses.
REQ-008 SHALL have port: Write_Reg  output  1  register-file write enable.
REQ-009 SHALL have port: ALU_OP  output  3  ALU operation select.
REQ-010 SHALL have ports: ZF, OF  input  1 each  ALU zero and overflow flags.
REQ-011 SHALL have ports: done, err_illegal, err_ovf  output  1 each  one-cycle completion/error pulses.
REQ-012 SHALL have ports: zf_q, of_q  output  1 each  sticky copies of ZF/OF from the last executed instruction.

Function
REQ-013 SHALL implement FSM IDLE -> DECODE -> EXEC -> WB -> IDLE; all outputs registered.
REQ-014 IDLE: instr_ready=1; instr latched on the edge where instr_valid&instr_ready; next state DECODE.
REQ-015 instr_ready SHALL be 0 in DECODE, EXEC, WB; instr_valid ignored there (no second capture).
REQ-016 DECODE: funct map and->0, or->1, xor->2, inc(0x21)->3, add(0x20)->4, sub(0x22)->5, slt(0x2A)->6, sllv(0x04)->7.
REQ-017 DECODE: op!=0 or unmapped funct SHALL pulse err_illegal one cycle and return to IDLE; no Write_Reg.
REQ-018 EXEC: R_Addr_A=rs, R_Addr_B=rt, W_Addr=rd, ALU_OP driven and held through WB; Write_Reg=0.
REQ-019 WB: ZF/OF sampled into zf_q/of_q; done pulses one cycle; Write_Reg=1 for exactly this cycle unless suppressed.
REQ-020 Suppression: OF=1 with ALU_OP in {3,4,5} SHALL hold Write_Reg=0 and pulse err_ovf alongside done.
REQ-021 Suppression: ZERO_REG_PROTECT=1 and rd==0 SHALL hold Write_Reg=0; done still pulses.
REQ-022 Latency: accept edge N -> WB (Write_Reg/done high) during cycle N+3; throughput one instruction per 4 cycles.
REQ-023 In IDLE, addresses and ALU_OP SHALL keep their last values; Write_Reg=0.

Reset
REQ-024 Reset sampled high SHALL force IDLE from any state, aborting in-flight work with no write.
REQ-025 Post-reset values: instr_ready=1; Write_Reg, done, err_illegal, err_ovf, zf_q, of_q = 0; R_Addr_A, R_Addr_B, W_Addr, ALU_OP = 0.
REQ-026 Reset SHALL take priority over a simultaneous instr_valid (instruction not captured).

Structure
REQ-027 Shared package SHALL hold ALU_OP encodings, funct codes, FSM state encoding.
REQ-028 Funct-to-ALU_OP mapping SHALL be a combinational sub-module alu_funct_decode (funct in, ALU_OP + legal out).

Verification
REQ-029 Reset, then instr=0x00221820 (add r3,r1,r2) accepted at edge N -> at N+3: R_Addr_A=1, R_Addr_B=2, W_Addr=3, ALU_OP=4, Write_Reg=1 and done=1 for one cycle.
REQ-030 instr=0x00A62022 (sub r4,r5,r6) with OF=1 in WB -> ALU_OP=5, Write_Reg=0, err_ovf=1, done=1, of_q=1.
REQ-031 instr=0x0022183F (funct 0x3F) -> err_illegal=1 at N+1, Write_Reg never 1, instr_ready=1 at N+2.
REQ-032 instr=0x00220020 (rd=0), ZERO_REG_PROTECT=1 -> done=1 at N+3, Write_Reg=0.
REQ-033 instr_valid held high over two words -> second captured only at the next IDLE edge; Write_Reg pulses exactly 4 cycles apart.
REQ-034 Reset asserted during EXEC -> next cycle IDLE, Write_Reg never asserts, all outputs at REQ-025 values.

Source files
------------

// File: rtl/reg_alu_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_alu_ctrl_pkg : shared ALU_OP encodings, R-type funct codes, FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package reg_alu_ctrl_pkg;

  localparam logic [2:0] c_ALU_AND  = 3'd0;
  localparam logic [2:0] c_ALU_OR   = 3'd1;
  localparam logic [2:0] c_ALU_XOR  = 3'd2;
  localparam logic [2:0] c_ALU_INC  = 3'd3;
  localparam logic [2:0] c_ALU_ADD  = 3'd4;
  localparam logic [2:0] c_ALU_SUB  = 3'd5;
  localparam logic [2:0] c_ALU_SLT  = 3'd6;
  localparam logic [2:0] c_ALU_SLLV = 3'd7;

  localparam logic [5:0] c_FN_AND  = 6'h24;
  localparam logic [5:0] c_FN_OR   = 6'h25;
  localparam logic [5:0] c_FN_XOR  = 6'h26;
  localparam logic [5:0] c_FN_INC  = 6'h21;
  localparam logic [5:0] c_FN_ADD  = 6'h20;
  localparam logic [5:0] c_FN_SUB  = 6'h22;
  localparam logic [5:0] c_FN_SLT  = 6'h2A;
  localparam logic [5:0] c_FN_SLLV = 6'h04;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  // Only the arithmetic ops can overflow; logic/shift/compare results never do.
  function automatic logic is_ovf_op(input logic [2:0] op);
    return (op == c_ALU_INC) || (op == c_ALU_ADD) || (op == c_ALU_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_alu_ctrl_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_funct_decode : combinational funct -> ALU_OP map with legality flag
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_funct_decode
  import reg_alu_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_legal
);

  always_comb begin
    o_alu_op = c_ALU_AND;
    o_legal  = 1'b1;
    case (i_funct)
      c_FN_AND:  o_alu_op = c_ALU_AND;
      c_FN_OR:   o_alu_op = c_ALU_OR;
      c_FN_XOR:  o_alu_op = c_ALU_XOR;
      c_FN_INC:  o_alu_op = c_ALU_INC;
      c_FN_ADD:  o_alu_op = c_ALU_ADD;
      c_FN_SUB:  o_alu_op = c_ALU_SUB;
      c_FN_SLT:  o_alu_op = c_ALU_SLT;
      c_FN_SLLV: o_alu_op = c_ALU_SLLV;
      default:   o_legal  = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reg_alu_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_alu_ctrl : 4-state R-type controller driving register-file/ALU controls
// Rev 1.0
// ----------------------------------------------------------------------------
module reg_alu_ctrl
  import reg_alu_ctrl_pkg::*;
#(
  parameter int ZERO_REG_PROTECT = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  R_Addr_A,
  output logic [4:0]  R_Addr_B,
  output logic [4:0]  W_Addr,
  output logic        Write_Reg,
  output logic [2:0]  ALU_OP,
  input  logic        ZF,
  input  logic        OF,
  output logic        done,
  output logic        err_illegal,
  output logic        err_ovf,
  output logic        zf_q,
  output logic        of_q
);

  state_t      r_state;
  logic [31:0] r_instr;
  logic [2:0]  w_dec_op;
  logic        w_dec_legal;
  logic        w_illegal;
  logic        w_ovf_sup;
  logic        w_zero_sup;

  alu_funct_decode u_dec (
    .i_funct  (r_instr[5:0]),
    .o_alu_op (w_dec_op),
    .o_legal  (w_dec_legal)
  );

  assign w_illegal  = (r_instr[31:26] != 6'd0) || !w_dec_legal;
  assign w_ovf_sup  = OF && is_ovf_op(ALU_OP);
  assign w_zero_sup = (ZERO_REG_PROTECT != 0) && (W_Addr == 5'd0);

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_instr     <= 32'd0;
      instr_ready <= 1'b1;
      R_Addr_A    <= 5'd0;
      R_Addr_B    <= 5'd0;
      W_Addr      <= 5'd0;
      ALU_OP      <= 3'd0;
      Write_Reg   <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_ovf     <= 1'b0;
      zf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      Write_Reg   <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_ovf     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            r_instr     <= instr;
            instr_ready <= 1'b0;
            r_state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_illegal) begin
            err_illegal <= 1'b1;
            instr_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            R_Addr_A <= r_instr[25:21];
            R_Addr_B <= r_instr[20:16];
            W_Addr   <= r_instr[15:11];
            ALU_OP   <= w_dec_op;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: r_state <= S_WB;
        S_WB: begin
          // Flags are final by the end of WB, so the write decision uses them here.
          zf_q        <= ZF;
          of_q        <= OF;
          done        <= 1'b1;
          err_ovf     <= w_ovf_sup;
          Write_Reg   <= !w_ovf_sup && !w_zero_sup;
          instr_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_alu_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reg_alu_ctrl : scoreboard bench for reg_alu_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_reg_alu_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic        Write_Reg;
  logic [2:0]  ALU_OP;
  logic        ZF, OF;
  logic        done, err_illegal, err_ovf, zf_q, of_q;

  typedef struct {
    logic [4:0] ra, rb, wa;
    logic [2:0] op;
    logic       ill, ovf, wr, zf, of;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  reg_alu_ctrl #(.ZERO_REG_PROTECT(1)) dut (
    .clk(clk), .Reset(Reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .W_Addr(W_Addr), .Write_Reg(Write_Reg), .ALU_OP(ALU_OP), .ZF(ZF), .OF(OF),
    .done(done), .err_illegal(err_illegal), .err_ovf(err_ovf),
    .zf_q(zf_q), .of_q(of_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic of, input logic zf);
    exp_t e;
    logic [2:0] op;
    logic       m;
    m = 1'b1;
    op = 3'd0;
    case (w[5:0])
      6'h24: op = 3'd0;
      6'h25: op = 3'd1;
      6'h26: op = 3'd2;
      6'h21: op = 3'd3;
      6'h20: op = 3'd4;
      6'h22: op = 3'd5;
      6'h2A: op = 3'd6;
      6'h04: op = 3'd7;
      default: m = 1'b0;
    endcase
    e.ra  = w[25:21];
    e.rb  = w[20:16];
    e.wa  = w[15:11];
    e.op  = op;
    e.ill = (w[31:26] != 6'd0) || !m;
    e.ovf = !e.ill && of && (op == 3'd3 || op == 3'd4 || op == 3'd5);
    e.wr  = !e.ill && !e.ovf && (w[15:11] != 5'd0);
    e.zf  = zf;
    e.of  = of;
    return e;
  endfunction

  // Completion monitor: every done / err_illegal pulse retires one expectation.
  always @(negedge clk) begin
    if (!Reset) begin
      if (Write_Reg && !done) chk("stray_wr", 32'(Write_Reg), 32'd0);
      if (done || err_illegal) begin
        if (exp_q.size() == 0) begin
          chk("unexp_cmpl", 32'({done, err_illegal}), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("err_illegal", 32'(err_illegal), 32'(e.ill));
          chk("done", 32'(done), 32'(!e.ill));
          chk("Write_Reg", 32'(Write_Reg), 32'(e.wr));
          chk("err_ovf", 32'(err_ovf), 32'(e.ovf));
          if (!e.ill) begin
            chk("R_Addr_A", 32'(R_Addr_A), 32'(e.ra));
            chk("R_Addr_B", 32'(R_Addr_B), 32'(e.rb));
            chk("W_Addr", 32'(W_Addr), 32'(e.wa));
            chk("ALU_OP", 32'(ALU_OP), 32'(e.op));
            chk("zf_q", 32'(zf_q), 32'(e.zf));
            chk("of_q", 32'(of_q), 32'(e.of));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, then wait (bounded) for its completion pulse and check latency.
  task automatic run(input logic [31:0] w, input logic of, input logic zf);
    exp_t e;
    int   lat;
    e = model(w, of, zf);
    exp_q.push_back(e);
    instr = w; OF = of; ZF = zf; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("ready_busy", 32'(instr_ready), 32'(e.ill ? 1'b0 : 1'b0));
    lat = 0;
    while (!(done || err_illegal) && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), e.ill ? 32'd1 : 32'd3);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  initial begin
    logic [5:0] fns [8];
    int         wr_t [$];
    int         wcnt;
    fns = '{6'h24, 6'h25, 6'h26, 6'h21, 6'h20, 6'h22, 6'h2A, 6'h04};

    // Reset with a simultaneous valid word: the word must not be captured.
    Reset = 1'b1; instr_valid = 1'b1; instr = 32'h00221820; ZF = 1'b0; OF = 1'b0;
    repeat (3) tick();
    Reset = 1'b0; instr_valid = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_wr", 32'(Write_Reg), 32'd0);
    chk("rst_addr", 32'({R_Addr_A, R_Addr_B, W_Addr}), 32'd0);
    chk("rst_op", 32'(ALU_OP), 32'd0);
    chk("rst_flags", 32'({done, err_illegal, err_ovf, zf_q, of_q}), 32'd0);
    repeat (4) tick();
    chk("no_capture_in_rst", 32'(instr_ready), 32'd1);

    // add r3,r1,r2 then explicit pulse-width check
    run(32'h00221820, 1'b0, 1'b0);
    chk("add_wr", 32'(Write_Reg), 32'd1);
    tick();
    chk("add_wr_1cyc", 32'({Write_Reg, done}), 32'd0);

    // sub r4,r5,r6 with overflow
    run(32'h00A62022, 1'b1, 1'b0);
    chk("sub_ovf", 32'({err_ovf, Write_Reg, of_q}), 32'b101);
    tick();

    // illegal funct, ready back by N+2
    run(32'h0022183F, 1'b0, 1'b0);
    tick();
    chk("ill_ready", 32'(instr_ready), 32'd1);

    // nonzero opcode is illegal too
    run(32'h08221820, 1'b0, 1'b0);
    tick();

    // rd == 0 suppressed write
    run(32'h00220020, 1'b0, 1'b1);
    chk("rd0_wr", 32'({done, Write_Reg}), 32'b10);
    tick();

    // all functs with random registers and flags
    for (int i = 0; i < 8; i++) begin
      run(mk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(1, 31)), fns[i]),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    // inc with overflow is suppressed, slt with OF is not
    run(mk(5'd9, 5'd0, 5'd10, 6'h21), 1'b1, 1'b0);
    tick();
    run(mk(5'd9, 5'd8, 5'd10, 6'h2A), 1'b1, 1'b1);
    tick();

    // valid held across two words: one capture per IDLE visit, pulses 4 apart
    exp_q.push_back(model(mk(5'd1, 5'd2, 5'd11, 6'h25), 1'b0, 1'b0));
    exp_q.push_back(model(mk(5'd3, 5'd4, 5'd12, 6'h24), 1'b0, 1'b0));
    OF = 1'b0; ZF = 1'b0;
    instr = mk(5'd1, 5'd2, 5'd11, 6'h25); instr_valid = 1'b1;
    tick();
    instr = mk(5'd3, 5'd4, 5'd12, 6'h24);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (Write_Reg) wr_t.push_back(c);
      if (c == 4) instr_valid = 1'b0;
    end
    chk("b2b_pulses", 32'(wr_t.size()), 32'd2);
    if (wr_t.size() == 2) begin
      chk("b2b_first", 32'(wr_t[0]), 32'd3);
      chk("b2b_gap", 32'(wr_t[1] - wr_t[0]), 32'd4);
    end

    // reset during EXEC aborts with no write
    instr = 32'h00221820; OF = 1'b1; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_addr", 32'({R_Addr_A, R_Addr_B, W_Addr, ALU_OP}), 32'd0);
    chk("abort_flags", 32'({Write_Reg, done, err_illegal, err_ovf, zf_q, of_q}), 32'd0);
    wcnt = 0;
    repeat (6) begin
      tick();
      if (Write_Reg || done) wcnt++;
    end
    chk("abort_no_wb", 32'(wcnt), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
